pipeline_stage_ctrl: RTL and testbench
======================================

Name: pipeline_stage_ctrl

Overview:
- Flow controller for a linear chain of STAGES pipeline data registers whose load enable is active-low (0 = load, 1 = hold).
- Tracks a valid bit per stage and drives each stage's active-low load enable.
- Provides a valid/ready handshake at the pipeline input and output, collapses bubbles, and supports flush, hold and drain.
- Sits between the upstream producer, the register chain and the downstream consumer; it carries no data itself.

Parameters:
- STAGES, 4, number of pipeline register stages controlled (2..16).
- CNT_W, 16, width of the optional statistics counters.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- in_valid  input  1  upstream has a data word on the stage-0 data input.
- in_ready  output  1  controller accepts the stage-0 word this cycle.
- out_valid  output  1  last stage holds a valid word.
- out_ready  input  1  downstream consumes the last-stage word this cycle.
- flush  input  1  synchronous discard of all in-flight words.
- hold  input  1  freeze the whole pipeline this cycle.
- drain_req  input  1  stop intake and empty the pipeline.
- drain_done  output  1  pipeline is empty after a drain request.
- stage_en_n  output  STAGES  active-low load enable per data register; bit i drives stage i.
- stage_valid  output  STAGES  per-stage valid bits (registered).
- occupancy  output  $clog2(STAGES+1)  number of valid stages (registered).

Behaviour:
- Reset (reset=0, asynchronous): stage_valid=0, occupancy=0, drain_done=0, FSM=RUN. While reset=0, stage_en_n is forced all-1 and in_ready=0. out_valid=0.
- Ready chain (combinational): rdy[STAGES]=out_ready & ~hold; rdy[i]=~stage_valid[i] | rdy[i+1].
- Upstream valid: up_v[0]=in_valid & in_ready; up_v[i]=stage_valid[i-1] for i>0.
- Stage enables: stage_en_n[i]=~(rdy[i] & up_v[i] & ~hold & ~flush). A register loads only when a real word arrives.
- Valid update at the clock edge, when rdy[i]=1 and no hold/flush: stage_valid[i] <= up_v[i]. Bubbles therefore advance and collapse.
- in_ready = rdy[0] & ~hold & ~flush & (FSM==RUN).
- out_valid = stage_valid[STAGES-1] & ~hold.
- Latency: a word accepted at cycle t is at the last stage at t+STAGES when there is no stall. Throughput is 1 word/cycle.
- Full pipeline with out_ready=0: in_ready=0 and all stage_en_n=1. If out_ready=1 on a full pipeline, the whole chain shifts and in_ready=1 in the same cycle.
- occupancy is updated every cycle as +1 on accept, -1 on output transfer, unchanged when both occur. It equals popcount(stage_valid) at all times.
- flush=1: at the next edge all stage_valid, occupancy and drain_done clear and FSM goes to RUN. Flush has priority over hold, drain_req and any transfer in the same cycle; no transfer happens on a flush cycle.
- hold=1 (no flush): state is unchanged, all stage_en_n=1, in_ready=0, out_valid=0.
- FSM:
  - RUN: if drain_req=1, go to DRAIN.
  - DRAIN: in_ready=0 and stages keep advancing. When occupancy=0 (including an entry with occupancy already 0), go to DONE at the next edge.
  - DONE: drain_done=1 (registered). When drain_req=0, go to RUN and clear drain_done.
- Reset mid-operation: all in-flight words are lost and the outputs return to their reset values immediately.

Optional Feature:
- Macro: PIPE_STATS_EN.
- Defined:
  - Adds output stat_accepted[CNT_W-1:0], which counts in_valid&in_ready cycles.
  - Adds output stat_stalls[CNT_W-1:0], which counts out_valid&~out_ready cycles.
  - Both counters saturate at all-ones, clear on reset and on flush, and count only when hold=0.
- Not defined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- STAGES=4, reset released, in_valid=1 for 6 cycles, out_ready=1 -> in_ready=1 throughout; first out_valid at cycle 4 after the first accept; 6 consecutive output transfers; occupancy peaks at 4.
- Fill 4 words with out_ready=0 -> after 4 accepts in_ready=0, occupancy=4, stage_en_n=4'b1111. Then out_ready=1 with in_valid=1 -> one transfer and one accept in the same cycle; occupancy stays 4.
- Bubble collapse: accept 1 word, idle 2 cycles, accept 1 word, out_ready=0 -> the words occupy stages 3 and 2; stage_valid=4'b1100.
- flush asserted with occupancy=3 and in_valid=1 -> no accept that cycle; next cycle stage_valid=0, occupancy=0, out_valid=0.
- drain_req=1 with occupancy=2 and out_ready=1 -> in_ready=0 immediately; drain_done=1 once occupancy reaches 0; drain_req=0 -> drain_done=0 and in_ready=1 next cycle.
- reset driven low mid-stream with occupancy=3 -> stage_valid=0, occupancy=0 and stage_en_n=1111 without waiting for a clock edge. With PIPE_STATS_EN defined, both stat counters read 0.

Source files
------------

// File: rtl/pipeline_stage_ctrl.sv
// Valid/ready flow controller for a chain of STAGES active-low-enabled data registers.
// Optional statistics counters are compiled in with PIPE_STATS_EN.
module pipeline_stage_ctrl #(
  parameter int unsigned STAGES = 4,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic                         out_valid,
  input  logic                         out_ready,
  input  logic                         flush,
  input  logic                         hold,
  input  logic                         drain_req,
  output logic                         drain_done,
  output logic [STAGES-1:0]            stage_en_n,
  output logic [STAGES-1:0]            stage_valid,
  output logic [$clog2(STAGES+1)-1:0]  occupancy
`ifdef PIPE_STATS_EN
  ,
  output logic [CNT_W-1:0]             stat_accepted,
  output logic [CNT_W-1:0]             stat_stalls
`endif
);

  localparam int unsigned OCC_W = $clog2(STAGES + 1);

  typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_DONE} state_t;

  state_t             state, state_nxt;
  logic [STAGES:0]    rdy;
  logic [STAGES-1:0]  up_v;
  logic [STAGES-1:0]  valid_nxt;
  logic [OCC_W-1:0]   occ_nxt;
  logic               accept;
  logic               deliver;

  if (STAGES < 2 || STAGES > 16 || CNT_W < 1) begin : g_bad_cfg
    $error("pipeline_stage_ctrl: unsupported parameter values");
  end

  // Ready ripples back from the consumer; an empty stage is always ready.
  always_comb begin
    rdy        = '0;
    up_v       = '0;
    stage_en_n = '1;
    valid_nxt  = stage_valid;
    rdy[STAGES] = out_ready & ~hold;
    for (int i = int'(STAGES) - 1; i >= 0; i--) begin
      rdy[i] = ~stage_valid[i] | rdy[i+1];
    end
    in_ready  = reset & rdy[0] & ~hold & ~flush & (state == ST_RUN);
    out_valid = stage_valid[STAGES-1] & ~hold;
    accept    = in_valid & in_ready;
    deliver   = out_valid & out_ready;
    up_v      = {stage_valid[STAGES-2:0], accept};
    for (int i = 0; i < int'(STAGES); i++) begin
      stage_en_n[i] = ~(reset & rdy[i] & up_v[i] & ~hold & ~flush);
      if (rdy[i]) begin
        valid_nxt[i] = up_v[i];
      end
    end
  end

  // Occupancy tracks accepts and deliveries rather than recounting valid bits.
  always_comb begin
    occ_nxt = occupancy;
    case ({accept, deliver})
      2'b10:   occ_nxt = occupancy + OCC_W'(1);
      2'b01:   occ_nxt = occupancy - OCC_W'(1);
      default: occ_nxt = occupancy;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_RUN:   if (drain_req)            state_nxt = ST_DRAIN;
      ST_DRAIN: if (occupancy == '0)      state_nxt = ST_DONE;
      ST_DONE:  if (!drain_req)           state_nxt = ST_RUN;
      default:                            state_nxt = ST_RUN;
    endcase
  end

  // Flush wins over everything; hold freezes all state including the FSM.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ST_RUN;
      stage_valid <= '0;
      occupancy   <= '0;
      drain_done  <= 1'b0;
    end else if (flush) begin
      state       <= ST_RUN;
      stage_valid <= '0;
      occupancy   <= '0;
      drain_done  <= 1'b0;
    end else if (!hold) begin
      state       <= state_nxt;
      stage_valid <= valid_nxt;
      occupancy   <= occ_nxt;
      drain_done  <= (state_nxt == ST_DONE);
    end
  end

`ifdef PIPE_STATS_EN
  // Saturating event counters; both are idle while held.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stat_accepted <= '0;
      stat_stalls   <= '0;
    end else if (flush) begin
      stat_accepted <= '0;
      stat_stalls   <= '0;
    end else if (!hold) begin
      if (accept && stat_accepted != '1) begin
        stat_accepted <= stat_accepted + CNT_W'(1);
      end
      if (out_valid && !out_ready && stat_stalls != '1) begin
        stat_stalls <= stat_stalls + CNT_W'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_stage_ctrl.sv
// Self-checking bench for pipeline_stage_ctrl: directed scenarios plus random traffic
// compared against a word-position model of the pipeline.
module tb_pipeline_stage_ctrl;

  localparam int S     = 4;
  localparam int CNT_W = 16;

  logic             clk;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic             out_valid;
  logic             out_ready;
  logic             flush;
  logic             hold;
  logic             drain_req;
  logic             drain_done;
  logic [S-1:0]     stage_en_n;
  logic [S-1:0]     stage_valid;
  logic [2:0]       occupancy;
`ifdef PIPE_STATS_EN
  logic [CNT_W-1:0] stat_accepted;
  logic [CNT_W-1:0] stat_stalls;
`endif

  pipeline_stage_ctrl #(.STAGES(S), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .flush      (flush),
    .hold       (hold),
    .drain_req  (drain_req),
    .drain_done (drain_done),
    .stage_en_n (stage_en_n),
    .stage_valid(stage_valid),
    .occupancy  (occupancy)
`ifdef PIPE_STATS_EN
    ,
    .stat_accepted(stat_accepted),
    .stat_stalls  (stat_stalls)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: positions of in-flight words, oldest first; mode 0=run 1=drain 2=done.
  int           q[$];
  int           nq[$];
  int           mode;
  logic         dd;
  int           m_acc;
  int           m_stall;
  logic [S-1:0] e_en_n;
  logic         e_in_ready;
  logic         e_out_valid;
  logic         e_acc;

  function automatic logic [S-1:0] valid_vec();
    logic [S-1:0] v = '0;
    foreach (q[k]) v[q[k]] = 1'b1;
    return v;
  endfunction

  task automatic model_clear();
    q = {};
    mode = 0;
    dd = 1'b0;
    m_acc = 0;
    m_stall = 0;
  endtask

  // Each word steps forward when the slot ahead is free after older words have moved.
  task automatic predict(input logic iv, input logic ordy, input logic fl, input logic hd);
    int prev_after;
    int p;
    nq = {};
    e_en_n = '1;
    e_in_ready = 1'b0;
    e_acc = 1'b0;
    e_out_valid = (q.size() > 0 && q[0] == S - 1) && !hd;
    if (hd || fl) begin
      nq = q;
      return;
    end
    prev_after = S + 1;
    foreach (q[k]) begin
      p = q[k];
      if (p == S - 1) begin
        if (ordy) prev_after = S;
        else begin nq.push_back(p); prev_after = p; end
      end else if (prev_after != p + 1) begin
        nq.push_back(p + 1);
        e_en_n[p+1] = 1'b0;
        prev_after = p + 1;
      end else begin
        nq.push_back(p);
        prev_after = p;
      end
    end
    e_in_ready = (mode == 0) && !(nq.size() > 0 && nq[nq.size()-1] == 0);
    e_acc = iv && e_in_ready;
    if (e_acc) begin
      nq.push_back(0);
      e_en_n[0] = 1'b0;
    end
  endtask

  task automatic commit(input logic ordy, input logic fl, input logic hd, input logic dr);
    if (fl) begin
      q = {};
      mode = 0;
      dd = 1'b0;
      m_acc = 0;
      m_stall = 0;
    end else if (!hd) begin
      case (mode)
        0: if (dr) mode = 1;
        1: if (q.size() == 0) mode = 2;
        default: if (!dr) mode = 0;
      endcase
      dd = (mode == 2);
      if (e_acc && m_acc < (1 << CNT_W) - 1) m_acc++;
      if (e_out_valid && !ordy && m_stall < (1 << CNT_W) - 1) m_stall++;
      q = nq;
    end
  endtask

  // One clock: drive at negedge, check just after, then advance the model.
  task automatic cyc(input logic iv, input logic ordy, input logic fl, input logic hd,
                     input logic dr);
    @(negedge clk);
    in_valid = iv; out_ready = ordy; flush = fl; hold = hd; drain_req = dr;
    #1;
    predict(iv, ordy, fl, hd);
    chk("stage_valid", 32'(stage_valid), 32'(valid_vec()));
    chk("occupancy", 32'(occupancy), 32'(q.size()));
    chk("drain_done", 32'(drain_done), 32'(dd));
    chk("in_ready", 32'(in_ready), 32'(e_in_ready));
    chk("out_valid", 32'(out_valid), 32'(e_out_valid));
    chk("stage_en_n", 32'(stage_en_n), 32'(e_en_n));
`ifdef PIPE_STATS_EN
    chk("stat_accepted", 32'(stat_accepted), 32'(m_acc));
    chk("stat_stalls", 32'(stat_stalls), 32'(m_stall));
`endif
    commit(ordy, fl, hd, dr);
  endtask

  initial begin
    int first_acc, first_ov, n_acc, n_xfer, peak;
    logic dr_r;
    logic seen_done;

    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    flush = 1'b0; hold = 1'b0; drain_req = 1'b0;
    model_clear();
    #1;
    chk("rst_stage_valid", 32'(stage_valid), 32'h0);
    chk("rst_occupancy", 32'(occupancy), 32'h0);
    chk("rst_drain_done", 32'(drain_done), 32'h0);
    chk("rst_in_ready", 32'(in_ready), 32'h0);
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_stage_en_n", 32'(stage_en_n), 32'hF);
    @(negedge clk);
    reset = 1'b1;

    // Streaming: six words back to back with the consumer always ready.
    first_acc = -1; first_ov = -1; n_acc = 0; n_xfer = 0; peak = 0;
    for (int c = 0; c < 14; c++) begin
      cyc(c < 6, 1'b1, 1'b0, 1'b0, 1'b0);
      if (in_valid && in_ready) begin
        if (first_acc < 0) first_acc = c;
        n_acc++;
      end
      if (out_valid && out_ready) begin
        if (first_ov < 0) first_ov = c;
        n_xfer++;
      end
      if (int'(occupancy) > peak) peak = int'(occupancy);
    end
    chk("stream_accepts", 32'(n_acc), 32'd6);
    chk("stream_latency", 32'(first_ov - first_acc), 32'd4);
    chk("stream_transfers", 32'(n_xfer), 32'd6);
    chk("stream_peak_occ", 32'(peak), 32'd4);

    // Fill with a stalled consumer, then release it for one simultaneous in/out.
    for (int c = 0; c < 4; c++) cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    chk("full_occupancy", 32'(occupancy), 32'd4);
    chk("full_en_n", 32'(stage_en_n), 32'hF);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("full_shift_in_ready", 32'(in_ready), 32'd1);
    chk("full_shift_en_n", 32'(stage_en_n), 32'h0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("full_shift_occ", 32'(occupancy), 32'd4);
    for (int c = 0; c < 8; c++) cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

    // Bubble collapse: two words separated by idle cycles pack at the output end.
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int c = 0; c < 4; c++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("bubble_valid", 32'(stage_valid), 32'hC);

    // Flush at occupancy 3 with a word offered.
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("flush_occ_before", 32'(occupancy), 32'd3);
    chk("flush_in_ready", 32'(in_ready), 32'd0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("flush_valid", 32'(stage_valid), 32'h0);
    chk("flush_occ", 32'(occupancy), 32'd0);
    chk("flush_out_valid", 32'(out_valid), 32'd0);

    // Drain with two words in flight.
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("drain_occ_start", 32'(occupancy), 32'd2);
    seen_done = 1'b0;
    for (int c = 0; c < 12 && !seen_done; c++) begin
      cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
      chk("drain_in_ready", 32'(in_ready), 32'd0);
      if (drain_done) seen_done = 1'b1;
    end
    chk("drain_done_seen", 32'(seen_done), 32'd1);
    chk("drain_done_occ", 32'(occupancy), 32'd0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("undrain_done", 32'(drain_done), 32'd0);
    chk("undrain_in_ready", 32'(in_ready), 32'd1);

    // Random traffic against the model.
    dr_r = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(99, 0) < 4) dr_r = ~dr_r;
      cyc($urandom_range(99, 0) < 70, $urandom_range(99, 0) < 60,
          $urandom_range(99, 0) < 3, $urandom_range(99, 0) < 10, dr_r);
    end

    // Asynchronous reset in the middle of a cycle with three words in flight.
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int c = 0; c < 3; c++) cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("mid_occ_before", 32'(occupancy), 32'd3);
    #1;
    reset = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(stage_valid), 32'h0);
    chk("mid_rst_occ", 32'(occupancy), 32'h0);
    chk("mid_rst_en_n", 32'(stage_en_n), 32'hF);
    chk("mid_rst_in_ready", 32'(in_ready), 32'h0);
    chk("mid_rst_out_valid", 32'(out_valid), 32'h0);
`ifdef PIPE_STATS_EN
    chk("mid_rst_stat_acc", 32'(stat_accepted), 32'h0);
    chk("mid_rst_stat_stall", 32'(stat_stalls), 32'h0);
`endif
    model_clear();
    @(negedge clk);
    reset = 1'b1;
    for (int c = 0; c < 10; c++) cyc(1'b1, c[0], 1'b0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
